// File: rtl/soc_rst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_rst_pkg
// Description : Shared definitions for the SoC reset sequencer. Holds the
//               sequencer state encoding, the reset-cause encodings, and a
//               small helper used to size the sequencing counter.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_rst_pkg;

    // Sequencer state encoding
    typedef logic [2:0] state_t;

    localparam state_t S_WAIT_LOCK   = 3'd0;
    localparam state_t S_PERIPH_HOLD = 3'd1;
    localparam state_t S_CPU_DELAY   = 3'd2;
    localparam state_t S_RUN         = 3'd3;
    localparam state_t S_DBG_HOLD    = 3'd4;

    // Cause of the most recent reset sequence
    typedef logic [2:0] rst_cause_t;

    localparam rst_cause_t RST_CAUSE_POR = 3'd0;
    localparam rst_cause_t RST_CAUSE_PLL = 3'd1;
    localparam rst_cause_t RST_CAUSE_DBG = 3'd2;
    localparam rst_cause_t RST_CAUSE_SW  = 3'd3;
    localparam rst_cause_t RST_CAUSE_WDT = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soc_rst_sync.sv
`default_nettype none
// ============================================================================
// Module      : soc_rst_sync
// Description : Multi-flop synchronizer with asynchronous clear, used to
//               bring the PLL lock indication into the system clock domain.
// Ports       : clk  - destination clock
//               rst  - asynchronous active-high clear
//               i_d  - asynchronous input
//               o_q  - synchronized output (STAGES cycles of latency)
// Revision    : 1.0 - initial release
// ============================================================================
module soc_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/soc_rst_seq.sv
`default_nettype none
// ============================================================================
// Module      : soc_rst_seq
// Description : SoC reset sequencer. Qualifies PLL lock, releases the
//               interconnect/peripheral reset first and the CPU reset later,
//               re-sequences on lock loss, debug ndmreset or software reset,
//               and records the cause of the last reset.
// Ports       : sys_clk        - system clock
//               sys_rst        - asynchronous active-high power-on/pad reset
//               pll_locked_i   - PLL lock (asynchronous)
//               dbg_rst_req_i  - debug ndmreset request (level)
//               sw_rst_req_i   - software reset request (one-cycle pulse)
//               wdt_kick_i     - watchdog kick (only with SOC_RST_SEQ_WDT_EN)
//               periph_rst_b_o - active-low interconnect/peripheral reset
//               cpu_rst_b_o    - active-low CPU core reset
//               rst_busy_o     - high while any sequenced reset is asserted
//               rst_cause_o    - 0 POR, 1 PLL, 2 DBG, 3 SW, 4 WDT
// Options     : SOC_RST_SEQ_WDT_EN - adds the watchdog timeout trigger
// Revision    : 1.0 - initial release
// ============================================================================
module soc_rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 4,
    parameter int PERIPH_HOLD = 16,
    parameter int CPU_DELAY   = 8
`ifdef SOC_RST_SEQ_WDT_EN
    ,
    parameter int WDT_TIMEOUT = 65536
`endif
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pll_locked_i,
    input  logic       dbg_rst_req_i,
    input  logic       sw_rst_req_i,
`ifdef SOC_RST_SEQ_WDT_EN
    input  logic       wdt_kick_i,
`endif
    output logic       periph_rst_b_o,
    output logic       cpu_rst_b_o,
    output logic       rst_busy_o,
    output logic [2:0] rst_cause_o
);

    import soc_rst_pkg::*;

    localparam int c_CNT_MAX = max3(LOCK_FILTER, PERIPH_HOLD, CPU_DELAY);
    localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_FILT_LAST  = c_CNT_W'(LOCK_FILTER - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD  = c_CNT_W'(PERIPH_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_DELAY_LOAD = c_CNT_W'(CPU_DELAY - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    logic               w_lock;
    logic               w_wdt_expire;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               r_periph_rst_b;
    logic               w_periph_nxt;
    logic               r_cpu_rst_b;
    logic               w_cpu_nxt;
    logic               r_rst_busy;
    rst_cause_t         r_cause;
    rst_cause_t         w_cause_nxt;

    soc_rst_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (sys_clk),
        .rst (sys_rst),
        .i_d (pll_locked_i),
        .o_q (w_lock)
    );

`ifdef SOC_RST_SEQ_WDT_EN
    logic [31:0] r_wdt_cnt;

    // Runs only while the sequencer stays in S_RUN; a kick or any exit
    // from S_RUN restarts it, so it can never wrap.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wdt_cnt <= '0;
        end else if ((r_state == S_RUN) && (w_state_nxt == S_RUN) && !wdt_kick_i) begin
            r_wdt_cnt <= r_wdt_cnt + 32'd1;
        end else begin
            r_wdt_cnt <= '0;
        end
    end

    assign w_wdt_expire = (r_state == S_RUN) && !wdt_kick_i &&
                          (r_wdt_cnt == 32'(WDT_TIMEOUT - 1));
`else
    assign w_wdt_expire = 1'b0;
`endif

    // Next-state logic. Every output is computed here and registered below,
    // so no input reaches an output pin combinationally.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_periph_nxt = r_periph_rst_b;
        w_cpu_nxt    = r_cpu_rst_b;
        w_cause_nxt  = r_cause;

        if (!w_lock && (r_state != S_WAIT_LOCK)) begin
            // Lock loss overrides everything outside the lock-wait state
            w_state_nxt  = S_WAIT_LOCK;
            w_cnt_nxt    = '0;
            w_periph_nxt = 1'b0;
            w_cpu_nxt    = 1'b0;
            w_cause_nxt  = RST_CAUSE_PLL;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    w_periph_nxt = 1'b0;
                    w_cpu_nxt    = 1'b0;
                    if (!w_lock) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt == c_FILT_LAST) begin
                        w_state_nxt = S_PERIPH_HOLD;
                        w_cnt_nxt   = c_HOLD_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end

                S_PERIPH_HOLD, S_CPU_DELAY: begin
                    if (dbg_rst_req_i) begin
                        w_state_nxt  = S_DBG_HOLD;
                        w_cnt_nxt    = '0;
                        w_periph_nxt = 1'b0;
                        w_cpu_nxt    = 1'b0;
                        w_cause_nxt  = RST_CAUSE_DBG;
                    end else if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end else if (r_state == S_PERIPH_HOLD) begin
                        w_periph_nxt = 1'b1;
                        w_state_nxt  = S_CPU_DELAY;
                        w_cnt_nxt    = c_DELAY_LOAD;
                    end else begin
                        w_cpu_nxt   = 1'b1;
                        w_state_nxt = S_RUN;
                    end
                end

                S_RUN: begin
                    if (dbg_rst_req_i) begin
                        w_state_nxt  = S_DBG_HOLD;
                        w_cnt_nxt    = '0;
                        w_periph_nxt = 1'b0;
                        w_cpu_nxt    = 1'b0;
                        w_cause_nxt  = RST_CAUSE_DBG;
                    end else if (sw_rst_req_i) begin
                        // Clock is already qualified, so skip the lock filter
                        w_state_nxt  = S_PERIPH_HOLD;
                        w_cnt_nxt    = c_HOLD_LOAD;
                        w_periph_nxt = 1'b0;
                        w_cpu_nxt    = 1'b0;
                        w_cause_nxt  = RST_CAUSE_SW;
                    end else if (w_wdt_expire) begin
                        w_state_nxt  = S_PERIPH_HOLD;
                        w_cnt_nxt    = c_HOLD_LOAD;
                        w_periph_nxt = 1'b0;
                        w_cpu_nxt    = 1'b0;
                        w_cause_nxt  = RST_CAUSE_WDT;
                    end
                end

                S_DBG_HOLD: begin
                    w_periph_nxt = 1'b0;
                    w_cpu_nxt    = 1'b0;
                    if (!dbg_rst_req_i) begin
                        w_state_nxt = S_PERIPH_HOLD;
                        w_cnt_nxt   = c_HOLD_LOAD;
                    end
                end

                default: begin
                    w_state_nxt  = S_WAIT_LOCK;
                    w_cnt_nxt    = '0;
                    w_periph_nxt = 1'b0;
                    w_cpu_nxt    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state        <= S_WAIT_LOCK;
            r_cnt          <= '0;
            r_periph_rst_b <= 1'b0;
            r_cpu_rst_b    <= 1'b0;
            r_rst_busy     <= 1'b1;
            r_cause        <= RST_CAUSE_POR;
        end else begin
            r_state        <= w_state_nxt;
            r_cnt          <= w_cnt_nxt;
            r_periph_rst_b <= w_periph_nxt;
            r_cpu_rst_b    <= w_cpu_nxt;
            // CPU reset is always the last to release, so busy tracks it
            r_rst_busy     <= ~w_cpu_nxt;
            r_cause        <= w_cause_nxt;
        end
    end

    assign periph_rst_b_o = r_periph_rst_b;
    assign cpu_rst_b_o    = r_cpu_rst_b;
    assign rst_busy_o     = r_rst_busy;
    assign rst_cause_o    = r_cause;

endmodule
`default_nettype wire
